// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the programmable clock divider.
package clk_div_pkg;

   localparam int unsigned CNT_W        = 26;
   localparam int unsigned DEFAULT_HALF = 250000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STOP = 2'd2
   } state_e;

endpackage

// File: rtl/clk_div_if.sv
// Run request, configuration handshake and divided-clock outputs of clk_div_ctrl.
interface clk_div_if #(
   parameter int unsigned CNT_W = clk_div_pkg::CNT_W
) ();

   logic             en;
   logic             cfg_valid;
   logic [CNT_W-1:0] cfg_half;
   logic             cfg_ready;
   logic             clk_out;
   logic             tick;
   logic             busy;
   logic             cfg_err;

   modport master (
      output en, cfg_valid, cfg_half,
      input  cfg_ready, clk_out, tick, busy, cfg_err
   );

   modport slave (
      input  en, cfg_valid, cfg_half,
      output cfg_ready, clk_out, tick, busy, cfg_err
   );

endinterface

// File: rtl/clk_div_core.sv
// Half-period counter and output toggle flop; rise/fall flag the toggle taken at the next edge when run is high.
module clk_div_core #(
   parameter int unsigned CNT_W = 26
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic [CNT_W-1:0] half,
   input  logic             run,
   input  logic             clear,
   output logic             clk_out,
   output logic             rise,
   output logic             fall
);

   logic [CNT_W-1:0] cnt_q;
   logic             clk_q;
   logic             term_c;

   assign term_c  = (cnt_q == half - CNT_W'(1));
   assign rise    = term_c & ~clk_q;
   assign fall    = term_c &  clk_q;
   assign clk_out = clk_q;

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
         clk_q <= 1'b0;
      end else if (clear) begin
         cnt_q <= '0;
         clk_q <= 1'b0;
      end else if (run) begin
         if (term_c) begin
            cnt_q <= '0;
            clk_q <= ~clk_q;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/clk_div_ctrl.sv
// Programmable divided clock: run/stop FSM plus half-period configuration handshake.
module clk_div_ctrl #(
   parameter int unsigned CNT_W        = clk_div_pkg::CNT_W,
   parameter int unsigned DEFAULT_HALF = clk_div_pkg::DEFAULT_HALF
) (
   input  logic      clk_in,
   input  logic      reset,
   clk_div_if.slave  bus
);

   import clk_div_pkg::*;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] half_q;
   logic [CNT_W-1:0] pend_half_q;
   logic             pend_q;
   logic             tick_q;
   logic             cfg_err_q;

   logic             run_c, clear_c;
   logic             accept_c, apply_c, fall_ev_c;
   logic             clk_out, rise, fall;

   // Next state; a high phase is always allowed to finish before stopping
   always_comb begin
      state_d = state_q;
      run_c   = 1'b0;
      clear_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            clear_c = 1'b1;
            if (bus.en) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (bus.en) begin
               run_c = 1'b1;
            end else if (clk_out) begin
               run_c   = 1'b1;
               state_d = fall ? ST_IDLE : ST_STOP;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_STOP: begin
            run_c = 1'b1;
            if (fall) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   assign fall_ev_c = fall & run_c;
   assign accept_c  = bus.cfg_valid & ~pend_q;
   // Pending value only lands on a full-period boundary or while idle
   assign apply_c   = pend_q & (fall_ev_c | (state_d == ST_IDLE) | (state_q == ST_IDLE));

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         half_q      <= CNT_W'(DEFAULT_HALF);
         pend_half_q <= '0;
         pend_q      <= 1'b0;
         tick_q      <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         tick_q    <= rise & run_c;
         cfg_err_q <= accept_c & (bus.cfg_half == '0);
         if (apply_c) begin
            half_q <= pend_half_q;
            pend_q <= 1'b0;
         end
         if (accept_c && (bus.cfg_half != '0)) begin
            if (state_q == ST_IDLE) begin
               half_q <= bus.cfg_half;
            end else begin
               pend_q      <= 1'b1;
               pend_half_q <= bus.cfg_half;
            end
         end
      end
   end

   clk_div_core #(.CNT_W(CNT_W)) u_core (
      .clk_in  (clk_in),
      .reset   (reset),
      .half    (half_q),
      .run     (run_c),
      .clear   (clear_c),
      .clk_out (clk_out),
      .rise    (rise),
      .fall    (fall)
   );

   assign bus.clk_out   = clk_out;
   assign bus.tick      = tick_q;
   assign bus.busy      = pend_q;
   assign bus.cfg_ready = ~pend_q;
   assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Randomized and scenario bench for clk_div_ctrl against a phase-length reference model.
module tb_clk_div_ctrl;

   localparam int unsigned CW = 26;
   localparam int          DH = 4;

   logic clk_in = 1'b0;
   logic reset  = 1'b1;

   always #5 clk_in = ~clk_in;

   clk_div_if #(.CNT_W(CW)) bus ();

   clk_div_ctrl #(.CNT_W(CW), .DEFAULT_HALF(DH)) dut (
      .clk_in (clk_in),
      .reset  (reset),
      .bus    (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference: mode 0 idle, 1 run, 2 stop; m_left = cycles remaining in current phase
   int m_mode, m_left, m_half, m_pend_half;
   bit m_level, m_pend, m_tick, m_err;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_left = 0; m_half = DH; m_pend = 0; m_pend_half = 0;
      m_level = 0; m_tick = 0; m_err = 0;
   endtask

   task automatic model_step(input bit en, input bit cv, input int ch);
      int pre;
      bit acc, rise_ev, fall_ev;
      pre = m_mode; acc = cv && !m_pend; rise_ev = 0; fall_ev = 0;
      if (m_mode == 0) begin
         if (en) m_mode = 1;
      end else if (m_mode == 1 && !en && !m_level) begin
         m_mode = 0;
      end else begin
         if (m_left == 1) begin
            if (m_level) fall_ev = 1; else rise_ev = 1;
            m_level = !m_level;
         end else begin
            m_left--;
         end
         if (m_mode == 2 || !en) m_mode = fall_ev ? 0 : 2;
      end
      m_tick = rise_ev;
      m_err  = acc && (ch == 0);
      if (m_pend && (fall_ev || m_mode == 0 || pre == 0)) begin
         m_half = m_pend_half; m_pend = 0;
      end
      if (acc && ch != 0) begin
         if (pre == 0) m_half = ch;
         else begin m_pend = 1; m_pend_half = ch; end
      end
      if (rise_ev || fall_ev || (pre == 0 && m_mode == 1)) m_left = m_half;
   endtask

   task automatic check_outputs();
      chk("clk_out",   32'(bus.clk_out),   32'(m_level));
      chk("tick",      32'(bus.tick),      32'(m_tick));
      chk("busy",      32'(bus.busy),      32'(m_pend));
      chk("cfg_ready", 32'(bus.cfg_ready), 32'(!m_pend));
      chk("cfg_err",   32'(bus.cfg_err),   32'(m_err));
   endtask

   task automatic cyc(input bit en, input bit cv, input int ch);
      bus.en = en; bus.cfg_valid = cv; bus.cfg_half = CW'(ch);
      @(posedge clk_in);
      model_step(en, cv, ch);
      #1;
      check_outputs();
      bus.cfg_valid = 1'b0;
   endtask

   // Reset asserted between edges so the outputs must clear without a clock
   task automatic do_reset();
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check_outputs();
      repeat (2) @(posedge clk_in);
      #1;
      reset = 1'b1;
      check_outputs();
   endtask

   task automatic run_until_phase(input string tag, input bit level, input int left);
      bit ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         if (m_mode == 1 && m_level == level && m_left == left) ok = 1;
         else cyc(1, 0, 0);
      end
      chk(tag, 32'(ok), 32'd1);
   endtask

   initial begin
      bit en_r;
      bus.en = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_half = '0;
      model_reset();
      #1 reset = 1'b0;
      #1 check_outputs();
      repeat (2) @(posedge clk_in);
      #1 reset = 1'b1;
      check_outputs();

      // basic run at the reset half-period
      repeat (24) cyc(1, 0, 0);

      // reconfigure at the start of a high phase, second offer must stall
      run_until_phase("reach_high", 1, DH);
      cyc(1, 1, 2);
      cyc(1, 1, 3);
      repeat (20) cyc(1, 0, 0);
      cyc(1, 1, 4);
      repeat (24) cyc(1, 0, 0);

      // zero half-period is rejected
      cyc(1, 1, 0);
      repeat (20) cyc(1, 0, 0);

      // graceful stop one cycle into a high phase, en re-asserted during STOP
      run_until_phase("reach_cnt1", 1, DH - 1);
      cyc(0, 0, 0);
      cyc(1, 0, 0);
      repeat (8) cyc(0, 0, 0);

      // minimum divisor loaded while idle
      cyc(0, 1, 1);
      repeat (12) cyc(1, 0, 0);

      // reset mid-high-phase with a pending value
      repeat (4) cyc(0, 0, 0);
      cyc(0, 1, DH);
      run_until_phase("reach_high2", 1, DH);
      cyc(1, 1, 2);
      chk("busy_before_reset", 32'(bus.busy), 32'd1);
      do_reset();
      repeat (24) cyc(1, 0, 0);

      // randomized traffic
      en_r = 1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 24) == 0) en_r = !en_r;
         if ($urandom_range(0, 999) == 0) do_reset();
         cyc(en_r, ($urandom_range(0, 7) == 0), int'($urandom_range(0, 5)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
